sig_monitor: RTL

//  Conflict/sequence monitor on the highway/country light outputs (hwy, cntry) of the

---
 rtl/sig_defs.sv | 18 +
 rtl/sig_phase_chk.sv | 62 ++++++
 rtl/sig_monitor.sv | 99 +++++++++
 3 files changed

// File: rtl/sig_defs.sv
// Colour encodings and monitor fault codes, shared with the signal controller.
package sig_defs;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] BADCOL = 2'd3;

    localparam logic [2:0] F_NONE         = 3'd0;
    localparam logic [2:0] F_CONFLICT     = 3'd1;
    localparam logic [2:0] F_BAD_CODE     = 3'd2;
    localparam logic [2:0] F_SKIP_YEL     = 3'd3;
    localparam logic [2:0] F_BAD_SEQ      = 3'd4;
    localparam logic [2:0] F_YEL_SHORT    = 3'd5;
    localparam logic [2:0] F_YEL_LONG     = 3'd6;
    localparam logic [2:0] F_ALLRED_SHORT = 3'd7;

endpackage

// File: rtl/sig_phase_chk.sv
// Per-approach sequence checker: tracks previous colour and yellow run length,
// reports the highest-priority per-approach fault (codes 2..6).
module sig_phase_chk
    import sig_defs::*;
#(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] col_i,
    input  logic       resync_i,
    output logic [2:0] code_o,
    output logic       is_red_o,
    output logic       red_to_green_o
);

    localparam logic [CNT_W-1:0] YMIN  = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] YLONG = CNT_W'(YEL_MAX + 1);
    localparam logic [CNT_W-1:0] YSAT  = '1;

    logic [1:0]       prev_q;
    logic [CNT_W-1:0] ycnt_q, ycnt_d;

    always_comb begin
        ycnt_d = '0;
        if (col_i == YELLOW)
            ycnt_d = (ycnt_q == YSAT) ? ycnt_q : ycnt_q + CNT_W'(1);
    end

    // On resync only the illegal-encoding check survives; transitions are not judged.
    always_comb begin
        code_o = F_NONE;
        if (col_i == BADCOL)
            code_o = F_BAD_CODE;
        else if (!resync_i) begin
            if (prev_q == GREEN && col_i == RED)
                code_o = F_SKIP_YEL;
            else if ((prev_q == RED && col_i == YELLOW) || (prev_q == YELLOW && col_i == GREEN))
                code_o = F_BAD_SEQ;
            else if (prev_q == YELLOW && col_i == RED && ycnt_q < YMIN)
                code_o = F_YEL_SHORT;
            else if (col_i == YELLOW && ycnt_d == YLONG)
                code_o = F_YEL_LONG;
        end
    end

    assign is_red_o       = (col_i == RED);
    assign red_to_green_o = !resync_i && (prev_q == RED) && (col_i == GREEN);

    always_ff @(posedge clock) begin
        if (clear) begin
            prev_q <= RED;
            ycnt_q <= '0;
        end else begin
            prev_q <= col_i;
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/sig_monitor.sv
// Conflict/sequence monitor for the highway/country signal heads; latches the
// first fault and commands all-flash-red until acknowledged.
module sig_monitor
    import sig_defs::*;
#(
    parameter int YEL_MIN    = 2,
    parameter int YEL_MAX    = 4,
    parameter int ALLRED_MIN = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       fault_ack,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_src,
    output logic       flash
);

    localparam logic [CNT_W-1:0] ARMIN = CNT_W'(ALLRED_MIN);
    localparam logic [CNT_W-1:0] ASAT  = '1;

    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic             src_q, src_d;
    logic [CNT_W-1:0] allred_q, allred_d;

    logic       ack_eff;
    logic [2:0] h_code, c_code, cand_code;
    logic       h_red, c_red, h_r2g, c_r2g, cand_src;

    assign ack_eff = fault_ack && fault_q;

    sig_phase_chk #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)) u_hwy (
        .clock(clock), .clear(clear), .col_i(hwy), .resync_i(ack_eff),
        .code_o(h_code), .is_red_o(h_red), .red_to_green_o(h_r2g)
    );

    sig_phase_chk #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)) u_cntry (
        .clock(clock), .clear(clear), .col_i(cntry), .resync_i(ack_eff),
        .code_o(c_code), .is_red_o(c_red), .red_to_green_o(c_r2g)
    );

    always_comb begin
        allred_d = '0;
        if (ack_eff)
            allred_d = ARMIN;
        else if (h_red && c_red)
            allred_d = (allred_q == ASAT) ? allred_q : allred_q + CNT_W'(1);
    end

    // Lowest code wins; hwy wins ties. r2g flags are already masked during resync.
    always_comb begin
        cand_code = F_NONE;
        cand_src  = 1'b0;
        if (!h_red && !c_red)
            cand_code = F_CONFLICT;
        else if (h_code != F_NONE && (c_code == F_NONE || h_code <= c_code))
            cand_code = h_code;
        else if (c_code != F_NONE) begin
            cand_code = c_code;
            cand_src  = 1'b1;
        end else if ((h_r2g || c_r2g) && allred_q < ARMIN)
            cand_code = F_ALLRED_SHORT;
    end

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        src_d   = src_q;
        if (!fault_q || ack_eff) begin
            fault_d = (cand_code != F_NONE);
            code_d  = cand_code;
            src_d   = cand_src;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            fault_q  <= 1'b0;
            code_q   <= F_NONE;
            src_q    <= 1'b0;
            allred_q <= ARMIN;
        end else begin
            fault_q  <= fault_d;
            code_q   <= code_d;
            src_q    <= src_d;
            allred_q <= allred_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_src  = src_q;
    assign flash      = fault_q;

endmodule
